// File: rtl/div_issue_ctrl_if.sv
// Issue-side bundle for div_issue_ctrl: upstream (ID/EX) handshake, flush,
// the iterative-divider request/result lines and the downstream (MEM) handshake.
// The controller uses the slave modport; the surrounding pipeline/divider uses master.
interface div_issue_ctrl_if #(
    parameter int DEST_W = 5
);
    // upstream
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [31:0]       in_x;
    logic [31:0]       in_y;
    logic [DEST_W-1:0] in_dest;
    logic              flush;

    // iterative divider
    logic              div_req;
    logic              div_signed;
    logic [31:0]       div_x;
    logic [31:0]       div_y;
    logic [31:0]       div_s;
    logic [31:0]       div_r;
    logic              div_done;

    // downstream
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic [DEST_W-1:0] out_dest;

    logic              busy;

    modport slave (
        input  in_valid, in_op, in_x, in_y, in_dest, flush,
        input  div_s, div_r, div_done,
        input  out_ready,
        output in_ready,
        output div_req, div_signed, div_x, div_y,
        output out_valid, out_result, out_dest,
        output busy
    );

    modport master (
        output in_valid, in_op, in_x, in_y, in_dest, flush,
        output div_s, div_r, div_done,
        output out_ready,
        input  in_ready,
        input  div_req, div_signed, div_x, div_y,
        input  out_valid, out_result, out_dest,
        input  busy
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issues one divide at a time to an iterative divider, holds the
// operands stable while it works, and returns quotient or remainder downstream.
//
// Optional feature: define DIV_ZERO_BYPASS_EN to short-circuit a zero divisor
// (quotient all ones, remainder = dividend) without starting the divider.
//
// state | meaning
// IDLE  | no operation held, ready to accept
// BUSY  | divider running on the held operands
// DONE  | result presented downstream (out_valid)
// DRAIN | flushed while running; keep div_req up until the divider finishes, drop result
module div_issue_ctrl #(
    parameter int DEST_W = 5
) (
    input  logic           clk,
    input  logic           resetn,
    div_issue_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [1:0]        op_q;
    logic [31:0]       x_q;
    logic [31:0]       y_q;
    logic [DEST_W-1:0] dest_q;
    logic [31:0]       result_q;

    logic              in_ready;
    logic              accept;
    logic              zero_bypass;
    logic              load_div;
    logic              load_bypass;
    logic              div_req;
    logic              out_valid;
    logic              busy;

`ifdef DIV_ZERO_BYPASS_EN
    assign zero_bypass = (bus.in_y == 32'd0);
`else
    assign zero_bypass = 1'b0;
`endif

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshakes and divider request.
    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        accept      = 1'b0;
        load_div    = 1'b0;
        load_bypass = 1'b0;
        div_req     = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;

        // resetn gates in_ready so nothing is offered while the block is held in reset.
        in_ready = resetn
                 & ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready))
                 & ~bus.flush;
        accept      = bus.in_valid & in_ready;
        load_bypass = accept & zero_bypass;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = zero_bypass ? DONE : BUSY;
                end
            end
            BUSY: begin
                div_req = 1'b1;
                busy    = 1'b1;
                // A flush coinciding with div_done has nothing left to drain.
                if (bus.div_done) begin
                    state_d  = bus.flush ? IDLE : DONE;
                    load_div = ~bus.flush;
                end else if (bus.flush) begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.out_ready) begin
                    if (accept) begin
                        state_d = zero_bypass ? DONE : BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                div_req = 1'b1;
                busy    = 1'b1;
                if (bus.div_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand holding registers, loaded only on an accepted request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q   <= 2'd0;
            x_q    <= 32'd0;
            y_q    <= 32'd0;
            dest_q <= '0;
        end else if (accept) begin
            op_q   <= bus.in_op;
            x_q    <= bus.in_x;
            y_q    <= bus.in_y;
            dest_q <= bus.in_dest;
        end
    end

    // Result register: divider result on completion, or the zero-divisor value on bypass.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result_q <= 32'd0;
        end else if (load_bypass) begin
            result_q <= bus.in_op[0] ? bus.in_x : 32'hFFFF_FFFF;
        end else if (load_div) begin
            result_q <= op_q[0] ? bus.div_r : bus.div_s;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.div_req    = div_req;
    assign bus.div_signed = div_req & op_q[1];
    assign bus.div_x      = x_q;
    assign bus.div_y      = y_q;
    assign bus.out_valid  = out_valid;
    assign bus.out_result = result_q;
    assign bus.out_dest   = dest_q;
    assign bus.busy       = busy;

endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 SHALL have parameter: DEST_W, default 5, width of the destination-register tag carried alongside the operation.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: in_valid input 1, in_ready output 1, upstream (ID/EX) handshake.
REQ-005 SHALL have port: in_op  input  2  bit0=1 selects remainder, bit0=0 selects quotient; bit1=1 selects signed.
REQ-006 SHALL have ports: in_x input 32 dividend, in_y input 32 divisor, in_dest input DEST_W tag.
REQ-007 SHALL have port: flush  input  1  cancel the current operation (exception/branch kill).
REQ-008 SHALL have ports: div_req output 1, div_signed output 1, div_x output 32, div_y output 32, which drive the iterative divider.
REQ-009 SHALL have ports: div_s input 32, div_r input 32, div_done input 1, which carry divider results and its completion flag.
REQ-010 SHALL have ports: out_valid output 1, out_ready input 1, out_result output 32, out_dest output DEST_W, the downstream (MEM) handshake.
REQ-011 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement the states IDLE, BUSY, DONE and DRAIN.
REQ-013 in_ready SHALL be (IDLE | (DONE & out_ready)) & ~flush.
REQ-014 Accept (in_valid & in_ready) SHALL latch op, x, y and dest into holding registers, and the state SHALL move to BUSY.
REQ-015 In BUSY and DRAIN, div_req SHALL be 1, with div_x, div_y and div_signed driven from the holding registers and held stable.
REQ-016 div_req SHALL stay high through the cycle in which div_done is sampled high, so the divider counter wraps to 0, and SHALL be 0 in IDLE and DONE.
REQ-017 In BUSY with div_done=1, out_result SHALL capture div_r if op bit0=1, else div_s, and the state SHALL move to DONE.
REQ-018 out_valid SHALL be 1 exactly in DONE, and out_result/out_dest SHALL remain stable while out_valid & ~out_ready.
REQ-019 In DONE, out_ready & ~in_valid SHALL move to IDLE, and out_ready & in_valid & ~flush SHALL move directly to BUSY (back-to-back issue, no bubble).
REQ-020 Latency SHALL be: accept at edge T, div_req high from T, div_done at the divider's 34th div_req cycle, out_valid the cycle after div_done.
REQ-021 flush in BUSY SHALL move the state to DRAIN, and DRAIN SHALL hold div_req=1 until div_done, then go to IDLE with no output.
REQ-022 flush in DONE SHALL move to IDLE and drop out_valid, and the result SHALL be discarded even if out_ready=1 in the same cycle.
REQ-023 flush in IDLE or DRAIN SHALL have no effect, and flush SHALL win over a simultaneous accept.
REQ-024 div_done received in IDLE or DONE SHALL be ignored.

Reset
REQ-025 On resetn=0, the state SHALL go to IDLE asynchronously.
REQ-026 During reset, in_ready, div_req, div_signed, out_valid and busy SHALL be 0, and out_result, out_dest and all holding registers SHALL be 0.
REQ-027 Reset mid-operation SHALL abandon the operation, and the divider SHALL be reset by the same reset tree.

Configuration
REQ-028 With DIV_ZERO_BYPASS_EN defined, an accept with in_y==0 SHALL go directly to DONE next cycle, never asserting div_req.
REQ-029 With DIV_ZERO_BYPASS_EN defined, the bypass result SHALL be 32'hFFFFFFFF for a quotient and in_x for a remainder, for both signed and unsigned operations.
REQ-030 Without DIV_ZERO_BYPASS_EN, a zero divisor SHALL take the normal divider path, and the result SHALL be whatever the divider returns.

Verification
REQ-031 SHALL test: signed quotient, x=-7 (32'hFFFFFFF9), y=2 -> out_result 32'hFFFFFFFD, out_valid 35 cycles after accept.
REQ-032 SHALL test: signed remainder, x=-7, y=2 -> out_result 32'hFFFFFFFF; unsigned quotient, 32'hFFFFFFFF/2 -> 32'h7FFFFFFF.
REQ-033 SHALL test: out_ready=0 for 10 cycles after DONE -> out_valid and result held stable, in_ready=0, div_req=0.
REQ-034 SHALL test: back-to-back, second op valid at the DONE&out_ready edge -> accepted the same cycle, div_req rises the next cycle, second result is correct.
REQ-035 SHALL test: flush at 10 cycles into BUSY -> DRAIN, div_req held until div_done, no out_valid, the next op's result is correct.
REQ-036 SHALL test: with DIV_ZERO_BYPASS_EN, x=5, y=0, remainder -> out_valid 1 cycle after accept, result 5, div_req never high.
